// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM state type for the IF-stage instruction cache.
package inst_cache_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [2:0] AXI_PROT_INSN  = 3'b100;
  localparam logic [7:0] AXI_LEN_LINE   = 8'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } icache_state_t;

endpackage

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache; a miss fetches one line as a single AXI INCR burst.
// state | meaning
// IDLE  | serve hits combinationally, latch line address on a miss
// REQ   | present AR for the latched line until accepted
// FILL  | write R beats into the line, mark it valid on rlast
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LINES  = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] sm_pc,
  output logic [31:0]           ir,
  output logic                  icache_valid,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = $clog2(BEATS);

  icache_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [BEAT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][BEATS];

  logic [IDX_W-1:0]      pc_index, miss_index;
  logic [TAG_W-1:0]      pc_tag, miss_tag;
  logic [BEAT_W-1:0]     pc_beat;
  logic [DATA_WIDTH-1:0] word;
  logic                  hit_line;
  logic                  fill_we, fill_done;

  assign pc_index   = sm_pc[OFF_W +: IDX_W];
  assign pc_tag     = sm_pc[ADDR_WIDTH-1 -: TAG_W];
  assign pc_beat    = sm_pc[3 +: BEAT_W];
  assign miss_index = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag   = miss_addr_q[ADDR_WIDTH-1 -: TAG_W];

  assign hit_line     = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign icache_valid = hit_line && (state_q == IDLE) && !reset;
  assign word         = data_q[pc_index][pc_beat];
  assign ir           = sm_pc[2] ? word[63:32] : word[31:0];

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = miss_addr_q;
  assign m_axi_arlen   = AXI_LEN_LINE;
  assign m_axi_arsize  = AXI_SIZE_8B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = AXI_PROT_INSN;

  // Response id/status carry no information for a read-only line fill.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rid, m_axi_rresp, sm_pc[1:0]};

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    cnt_d         = cnt_q;
    fill_we       = 1'b0;
    fill_done     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit_line) begin
          miss_addr_d = {sm_pc[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          state_d     = REQ;
        end
      end
      REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (m_axi_rlast) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The bus resets with us, so handshakes are suppressed in the reset cycle.
    if (reset) begin
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      cnt_q       <= cnt_d;
      if (fill_done) valid_q[miss_index] <= 1'b1;
    end
  end

  // Tag and data arrays are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (fill_we && !reset) data_q[miss_index][cnt_q] <= m_axi_rdata;
    if (fill_done && !reset) tag_q[miss_index] <= miss_tag;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: bench-side AXI slave plus a line-level reference cache model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] sm_pc;
  logic [31:0] ir;
  logic        icache_valid;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  inst_cache dut (
    .clk(clk), .reset(reset), .sm_pc(sm_pc), .ir(ir), .icache_valid(icache_valid),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  always @(posedge clk) if (m_axi_arvalid === 1'b1 && m_axi_arready === 1'b1) hs_count++;

  // Reference model: what each line holds, as seen from the core.
  bit          ref_valid [64];
  bit [51:0]   ref_tag   [64];
  logic [63:0] ref_data  [64][8];
  bit          ref_known [64][8];
  logic [63:0] beat_data [8];

  function automatic logic [31:0] exp_ir(input logic [63:0] pc);
    logic [63:0] w;
    w = ref_data[pc[11:6]][pc[5:3]];
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic void random_beats();
    for (int k = 0; k < 8; k++) beat_data[k] = {$urandom, $urandom};
  endfunction

  function automatic void clear_valid();
    for (int k = 0; k < 64; k++) ref_valid[k] = 1'b0;
  endfunction

  // Presents pc at the current negedge; on a miss plays the AXI slave for the line fill.
  task automatic run_fetch(input logic [63:0] pc, input int ar_delay, input int gap_pct,
                           input int nbeats, input int abort_after, input bit wiggle);
    int          idx, waited, i, hs0;
    logic [63:0] line;
    bit          exp_hit;
    idx  = int'(pc[11:6]);
    line = {pc[63:6], 6'b0};
    sm_pc = pc;
    #1;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == pc[63:12]);
    checks++;
    if (icache_valid !== exp_hit) begin
      errors++;
      $display("FAIL hit pc=%h: got %b expected %b", pc, icache_valid, exp_hit);
    end
    if (exp_hit) begin
      if (ref_known[idx][pc[5:3]]) begin
        checks++;
        if (ir !== exp_ir(pc)) begin
          errors++;
          $display("FAIL hit_ir pc=%h: got %h expected %h", pc, ir, exp_ir(pc));
        end
      end
      @(negedge clk);
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL no_ar_on_hit pc=%h: got arvalid=%b expected 0", pc, m_axi_arvalid);
      end
      return;
    end
    hs0 = hs_count;
    @(negedge clk);
    waited = 0;
    while (m_axi_arvalid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (m_axi_arvalid !== 1'b1 || waited != 0) begin
      errors++;
      $display("FAIL ar_latency pc=%h: got %0d extra cycles arvalid=%b expected 0 cycles", pc, waited, m_axi_arvalid);
    end
    if (m_axi_arvalid !== 1'b1) return;
    checks++;
    if (m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01 ||
        m_axi_arprot !== 3'b100 || m_axi_arid !== 13'd0 || m_axi_arlock !== 1'b0 ||
        m_axi_arcache !== 4'd0) begin
      errors++;
      $display("FAIL ar_const: got len=%h size=%h burst=%h prot=%h id=%h lock=%b cache=%h expected 07 3 1 4 0 0 0",
               m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot, m_axi_arid, m_axi_arlock, m_axi_arcache);
    end
    for (int d = 0; d <= ar_delay; d++) begin
      if (wiggle) sm_pc = {$urandom, $urandom} & ~64'h3;
      if (d == ar_delay) m_axi_arready = 1'b1;
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== line || icache_valid !== 1'b0) begin
        errors++;
        $display("FAIL ar_hold cycle %0d: got arvalid=%b araddr=%h icv=%b expected 1 %h 0",
                 d, m_axi_arvalid, m_axi_araddr, icache_valid, line);
      end
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1 || hs_count - hs0 != 1) begin
      errors++;
      $display("FAIL fill_entry: got arvalid=%b rready=%b handshakes=%0d expected 0 1 1",
               m_axi_arvalid, m_axi_rready, hs_count - hs0);
    end
    i = 0;
    while (i < nbeats) begin
      if (abort_after >= 0 && i == abort_after) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        reset        = 1'b1;
        #1;
        checks++;
        if ({m_axi_arvalid, m_axi_rready, icache_valid} !== 3'b000) begin
          errors++;
          $display("FAIL reset_mid_fill: got arvalid=%b rready=%b icv=%b expected 000",
                   m_axi_arvalid, m_axi_rready, icache_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_valid();
        sm_pc = pc;
        return;
      end
      if (wiggle) sm_pc = {$urandom, $urandom} & ~64'h3;
      if (int'($urandom_range(99)) < gap_pct) begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end else begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data[i];
        m_axi_rlast  = (i == nbeats - 1);
        ref_data[idx][i]  = beat_data[i];
        ref_known[idx][i] = 1'b1;
        i++;
      end
      #1;
      checks++;
      if (m_axi_rready !== 1'b1 || icache_valid !== 1'b0 || m_axi_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL fill_beat %0d: got rready=%b icv=%b arvalid=%b expected 1 0 0",
                 i, m_axi_rready, icache_valid, m_axi_arvalid);
      end
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rdata  = '0;
    sm_pc        = pc;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = pc[63:12];
    #1;
    checks++;
    if (icache_valid !== 1'b1 || m_axi_rready !== 1'b0) begin
      errors++;
      $display("FAIL post_fill pc=%h: got icv=%b rready=%b expected 1 0", pc, icache_valid, m_axi_rready);
    end
    if (ref_known[idx][pc[5:3]]) begin
      checks++;
      if (ir !== exp_ir(pc)) begin
        errors++;
        $display("FAIL post_fill_ir pc=%h: got %h expected %h", pc, ir, exp_ir(pc));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({m_axi_arvalid, m_axi_rready, icache_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got arvalid=%b rready=%b icv=%b expected 000",
               m_axi_arvalid, m_axi_rready, icache_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_valid();
  endtask

  task automatic test_cold_miss();
    for (int k = 0; k < 8; k++) beat_data[k] = 64'h0000_0001_0000_0000 + 64'(k);
    run_fetch(64'h1000, 0, 0, 8, -1, 1'b0);
  endtask

  task automatic test_hits();
    run_fetch(64'h1004, 0, 0, 8, -1, 1'b0);
    run_fetch(64'h1038, 0, 0, 8, -1, 1'b0);
    run_fetch(64'h103C, 0, 0, 8, -1, 1'b0);
    run_fetch(64'h1010, 0, 0, 8, -1, 1'b0);
  endtask

  task automatic test_conflict();
    random_beats();
    run_fetch(64'h2000, 0, 0, 8, -1, 1'b0);
    random_beats();
    run_fetch(64'h1000, 1, 0, 8, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    random_beats();
    run_fetch(64'h3080, 3, 40, 8, -1, 1'b1);
  endtask

  task automatic test_unaligned();
    random_beats();
    run_fetch(64'h1234, 0, 0, 8, -1, 1'b0);
    run_fetch(64'h1230, 0, 0, 8, -1, 1'b0);
  endtask

  task automatic test_short_burst();
    random_beats();
    run_fetch(64'h5040, 0, 0, 8, -1, 1'b0);
    random_beats();
    run_fetch(64'h9040, 0, 0, 3, -1, 1'b0);
    run_fetch(64'h905C, 0, 0, 8, -1, 1'b0);
    run_fetch(64'h9048, 0, 0, 8, -1, 1'b0);
  endtask

  task automatic test_reset_during_hit();
    run_fetch(64'h1004, 0, 0, 8, -1, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (icache_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit_gate: got icv=%b expected 0", icache_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_valid();
    random_beats();
    run_fetch(64'h1004, 0, 0, 8, -1, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    int hs0;
    random_beats();
    run_fetch(64'h7100, 0, 0, 8, 3, 1'b0);
    hs0 = hs_count;
    random_beats();
    run_fetch(64'h7100, 2, 20, 8, -1, 1'b0);
    checks++;
    if (hs_count - hs0 != 1) begin
      errors++;
      $display("FAIL refetch_after_reset: got %0d handshakes expected 1", hs_count - hs0);
    end
  endtask

  task automatic test_random();
    bit [51:0]   tags [4];
    bit [5:0]    idxs [4];
    logic [63:0] pc;
    tags = '{52'h1, 52'h2, 52'h3, 52'hF_FFFF_FFFF_FFFF};
    idxs = '{6'd0, 6'd1, 6'd2, 6'd63};
    for (int n = 0; n < 40; n++) begin
      pc = {tags[$urandom_range(3)], idxs[$urandom_range(3)], 3'($urandom_range(7)),
            1'($urandom_range(1)), 2'b00};
      random_beats();
      run_fetch(pc, int'($urandom_range(3)), 30, 8, -1, 1'b1);
    end
  endtask

  initial begin
    reset         = 1'b1;
    sm_pc         = '0;
    m_axi_arready = 1'b0;
    m_axi_rid     = 13'h1abc;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b10;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    for (int l = 0; l < 64; l++)
      for (int b = 0; b < 8; b++) ref_known[l][b] = 1'b0;
    clear_valid();
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_backpressure();
    test_unaligned();
    test_short_burst();
    test_reset_during_hit();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
